uart_tx_arbiter: RTL

- Shares one UART byte transmitter between NREQ independent requesters, such as the core and the debug/loader path.
- Requesters are served round-robin into a shared byte FIFO.
- A small sequencer drains the FIFO into the transmitter: one issue pulse per byte, then a wait for the transmitter's end-of-frame pulse.
- Sits between the requesters and the UART TX engine; it is the only driver of that engine's valid_send/data_send.

---
 rtl/uart_tx_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding a shared byte FIFO that a small
// sequencer drains into a single UART transmitter (one issue pulse per byte,
// then wait for the transmitter's end-of-frame pulse).
// Optional build macro UART_TX_ARB_TIMEOUT_EN adds a send_ready timeout and
// the sticky tx_err output.
module uart_tx_arbiter #(
    parameter int NREQ    = 2,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 20000
) (
    input  logic                                      clk,
    input  logic                                      rstn,
    input  logic [NREQ-1:0]                           req_valid,
    input  logic [8*NREQ-1:0]                         req_data,
    output logic [NREQ-1:0]                           req_ready,
    output logic                                      valid_send,
    output logic [7:0]                                data_send,
    input  logic                                      ready_send,
    output logic [$clog2(DEPTH):0]                    fifo_count,
    output logic                                      busy,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] last_src
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    output logic                                      tx_err
`endif
);

    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state;
    logic [SW-1:0]     ptr;
    logic [SW-1:0]     grant_idx;
    logic [SW-1:0]     cand;
    logic              grant_any;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [SW+7:0]     mem [DEPTH];
    logic [SW+7:0]     head;

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [31:0]       wait_cnt;
`endif

    assign fifo_full  = (fifo_count == CW'(DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign push       = grant_any && !fifo_full;
    // Pop coincides with the IDLE->ISSUE transition, since the issue outputs are registered.
    assign pop        = (state == S_IDLE) && !fifo_empty;
    assign head       = mem[rd_ptr];
    assign busy       = !fifo_empty || (state != S_IDLE);

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = SW'((32'(ptr) + k) % NREQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Ready only to the granted requester, and only while the FIFO has room.
    always_comb begin
        req_ready = '0;
        if (push) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // FIFO storage, tagged with the source index.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {grant_idx, req_data[{grant_idx, 3'b000} +: 8]};
        end
    end

    // FIFO pointers, occupancy and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ptr        <= SW'(NREQ - 1);
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                ptr    <= grant_idx;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Sequencer: issue one byte, then wait for the end-of-frame pulse.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_IDLE;
            valid_send <= 1'b0;
            data_send  <= '0;
            last_src   <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            wait_cnt   <= '0;
            tx_err     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state      <= S_ISSUE;
                        valid_send <= 1'b1;
                        data_send  <= head[7:0];
                        last_src   <= head[SW+7:8];
                    end
                end
                S_ISSUE: begin
                    state      <= S_WAIT;
                    valid_send <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    wait_cnt   <= '0;
`endif
                end
                S_WAIT: begin
                    if (ready_send) begin
                        state <= S_IDLE;
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    else if (wait_cnt == 32'(TIMEOUT - 1)) begin
                        state  <= S_IDLE;
                        tx_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
`endif
                end
                default: begin
                    state      <= S_IDLE;
                    valid_send <= 1'b0;
                end
            endcase
        end
    end

endmodule
